// File: rtl/note_round_ctrl_pkg.sv
// Shared definitions for the rhythm-game round controller: lane codes,
// playfield geometry and the round state encoding.
package note_round_ctrl_pkg;

  localparam int ROW_W = 3;

  localparam logic [ROW_W-1:0] LANE_NONE = 3'b000;
  localparam logic [ROW_W-1:0] LANE_3    = 3'b001;
  localparam logic [ROW_W-1:0] LANE_2    = 3'b010;
  localparam logic [ROW_W-1:0] LANE_1    = 3'b011;
  localparam logic [ROW_W-1:0] LANE_0    = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TICK = 3'd1,
    ST_SHIFT     = 3'd2,
    ST_CHECK     = 3'd3,
    ST_UPDATE    = 3'd4,
    ST_OVER      = 3'd5
  } state_t;

  // Unused codes 101-111 from the pattern source become an empty row.
  function automatic logic [ROW_W-1:0] lane_sanitize(input logic [ROW_W-1:0] code);
    case (code)
      LANE_NONE, LANE_3, LANE_2, LANE_1, LANE_0: return code;
      default:                                   return LANE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/note_round_ctrl_tick_timer.sv
// Loadable down-counter pacing note steps; zero is high once the count
// has run down, and the count holds at zero until the next load.
module tick_timer #(
  parameter logic [24:0] TICK_CYCLES = 25'd12500000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic zero
);

  logic [24:0] count;

  // NOTE: sequential state is always written with non-blocking assignments.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= TICK_CYCLES - 25'd1;
    end else if (en && (count != '0)) begin
      count <= count - 25'd1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/note_round_ctrl.sv
// Round controller: shifts the four-row playfield on each tick, runs the
// check_go/check_done handshake and folds the verdict into score/streak/lives.
module note_round_ctrl
  import note_round_ctrl_pkg::*;
#(
  parameter logic [24:0] TICK_CYCLES = 25'd12500000,
  parameter logic [3:0]  LIVES       = 4'd5,
  parameter int          SCORE_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ROW_W-1:0]     note_in,
  output logic                 note_rd,
  input  logic                 check_done,
  input  logic                 hit,
  input  logic                 miss,
  output logic                 check_go,
  output logic [4*ROW_W-1:0]   rows,
  output logic [ROW_W-1:0]     row_4,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   streak,
  output logic [3:0]           lives_left,
  output logic                 playing,
  output logic                 game_over
);

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [SCORE_W-1:0] SCORE_ONE = {{(SCORE_W-1){1'b0}}, 1'b1};

  state_t state;
  logic   hit_q;
  logic   miss_q;
  logic   tick_zero;
  logic   lose;

  // Counter sits preloaded outside WAIT_TICK, so every entry starts a full tick.
  tick_timer #(.TICK_CYCLES(TICK_CYCLES)) u_tick_timer (
    .clk   (clk),
    .reset (reset),
    .load  (state != ST_WAIT_TICK),
    .en    (state == ST_WAIT_TICK),
    .zero  (tick_zero)
  );

  assign row_4 = rows[ROW_W-1:0];

  // A life is lost on an explicit miss or on a note left unplayed; hit wins.
  assign lose = !hit_q && (miss_q || (row_4 != LANE_NONE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      rows       <= '0;
      score      <= '0;
      streak     <= '0;
      lives_left <= '0;
      check_go   <= 1'b0;
      note_rd    <= 1'b0;
      playing    <= 1'b0;
      game_over  <= 1'b0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      note_rd <= 1'b0;
      case (state)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            state      <= ST_WAIT_TICK;
            rows       <= '0;
            score      <= '0;
            streak     <= '0;
            lives_left <= LIVES;
            playing    <= 1'b1;
            game_over  <= 1'b0;
          end
        end
        ST_WAIT_TICK: begin
          if (tick_zero) begin
            state   <= ST_SHIFT;
            note_rd <= 1'b1;
          end
        end
        ST_SHIFT: begin
          rows     <= {lane_sanitize(note_in), rows[4*ROW_W-1:ROW_W]};
          check_go <= 1'b1;
          state    <= ST_CHECK;
        end
        ST_CHECK: begin
          if (check_done) begin
            hit_q    <= hit;
            miss_q   <= miss;
            check_go <= 1'b0;
            state    <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          if (hit_q) begin
            if (score != SCORE_MAX)  score  <= score + SCORE_ONE;
            if (streak != SCORE_MAX) streak <= streak + SCORE_ONE;
          end else if (lose) begin
            streak <= '0;
            if (lives_left != 4'd0) lives_left <= lives_left - 4'd1;
          end
          if (lose && (lives_left <= 4'd1)) begin
            state     <= ST_OVER;
            playing   <= 1'b0;
            game_over <= 1'b1;
          end else begin
            state <= ST_WAIT_TICK;
          end
        end
        default: begin
          state   <= ST_IDLE;
          playing <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_round_ctrl.sv
// Directed bench for note_round_ctrl with a short tick and 2-bit score so
// saturation and game-over are reachable in a few steps.
module tb_note_round_ctrl;

  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [2:0]    note_in;
  logic          note_rd;
  logic          check_done;
  logic          hit;
  logic          miss;
  logic          check_go;
  logic [11:0]   rows;
  logic [2:0]    row_4;
  logic [SW-1:0] score;
  logic [SW-1:0] streak;
  logic [3:0]    lives_left;
  logic          playing;
  logic          game_over;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [2:0]  note;
    int          nchk;
    logic        h;
    logic        m;
    logic [11:0] rows;
    logic [1:0]  score;
    logic [1:0]  streak;
    logic [3:0]  lives;
  } step_t;

  step_t tab [11];

  note_round_ctrl #(
    .TICK_CYCLES (25'd4),
    .LIVES       (4'd5),
    .SCORE_W     (SW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .note_in    (note_in),
    .note_rd    (note_rd),
    .check_done (check_done),
    .hit        (hit),
    .miss       (miss),
    .check_go   (check_go),
    .rows       (rows),
    .row_4      (row_4),
    .score      (score),
    .streak     (streak),
    .lives_left (lives_left),
    .playing    (playing),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One note step: wait for CHECK, answer on the nchk-th CHECK cycle, then
  // return one cycle after UPDATE so the new score/lives are visible.
  task automatic run_step(input logic [2:0] note, input int nchk, input logic h,
                          input logic m, output int go_cyc);
    logic prev_rd;
    bit   seen;
    prev_rd = 1'b0;
    seen    = 1'b0;
    note_in = note;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      if (check_go) begin
        seen = 1'b1;
        break;
      end
      prev_rd = note_rd;
    end
    go_cyc = cyc;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL check_go timeout: got 0 expected 1 (cycle %0d)", cyc);
      return;
    end
    check("note_rd pulse before CHECK", prev_rd, 1);
    check("note_rd low in CHECK", note_rd, 0);
    repeat (nchk - 1) begin
      @(posedge clk); #1;
      check("check_go held", check_go, 1);
    end
    check_done = 1'b1;
    hit        = h;
    miss       = m;
    @(posedge clk); #1;
    check_done = 1'b0;
    hit        = 1'b0;
    miss       = 1'b0;
    check("check_go low in UPDATE", check_go, 0);
    check("game_over low in UPDATE", game_over, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int go;
    int prev_go;
    bit seen;
    logic [2:0] go_notes [6];

    reset      = 1'b1;
    start      = 1'b0;
    note_in    = 3'b000;
    check_done = 1'b0;
    hit        = 1'b0;
    miss       = 1'b0;
    prev_go    = 0;

    //               note    nchk h     m     rows               score streak lives
    tab[0]  = '{3'b001, 2, 1'b0, 1'b0, 12'b001_000_000_000, 2'd0, 2'd0, 4'd5};
    tab[1]  = '{3'b001, 2, 1'b0, 1'b0, 12'b001_001_000_000, 2'd0, 2'd0, 4'd5};
    tab[2]  = '{3'b001, 2, 1'b0, 1'b0, 12'b001_001_001_000, 2'd0, 2'd0, 4'd5};
    tab[3]  = '{3'b001, 2, 1'b1, 1'b0, 12'b001_001_001_001, 2'd1, 2'd1, 4'd5};
    tab[4]  = '{3'b001, 2, 1'b1, 1'b0, 12'b001_001_001_001, 2'd2, 2'd2, 4'd5};
    tab[5]  = '{3'b010, 2, 1'b1, 1'b1, 12'b010_001_001_001, 2'd3, 2'd3, 4'd5};
    tab[6]  = '{3'b111, 2, 1'b1, 1'b0, 12'b000_010_001_001, 2'd3, 2'd3, 4'd5};
    tab[7]  = '{3'b011, 1, 1'b0, 1'b0, 12'b011_000_010_001, 2'd3, 2'd0, 4'd4};
    tab[8]  = '{3'b000, 3, 1'b0, 1'b0, 12'b000_011_000_010, 2'd3, 2'd0, 4'd3};
    tab[9]  = '{3'b100, 2, 1'b0, 1'b1, 12'b100_000_011_000, 2'd3, 2'd0, 4'd2};
    tab[10] = '{3'b000, 2, 1'b1, 1'b0, 12'b000_100_000_011, 2'd3, 2'd1, 4'd2};

    repeat (2) @(posedge clk);
    #1;
    check("reset rows", rows, 0);
    check("reset row_4", row_4, 0);
    check("reset score", score, 0);
    check("reset streak", streak, 0);
    check("reset lives_left", lives_left, 0);
    check("reset check_go", check_go, 0);
    check("reset note_rd", note_rd, 0);
    check("reset playing", playing, 0);
    check("reset game_over", game_over, 0);

    reset = 1'b0;
    @(posedge clk); #1;
    check("idle without start", playing, 0);

    // start stays high through the table: it must be ignored while playing
    start = 1'b1;
    @(posedge clk); #1;
    check("start playing", playing, 1);
    check("start lives", lives_left, 5);

    for (int i = 0; i < 11; i++) begin
      run_step(tab[i].note, tab[i].nchk, tab[i].h, tab[i].m, go);
      if (i > 0) check("step period", go - prev_go, tab[i-1].nchk + 6);
      prev_go = go;
      check("rows", rows, tab[i].rows);
      check("row_4", row_4, tab[i].rows[2:0]);
      check("score", score, tab[i].score);
      check("streak", streak, tab[i].streak);
      check("lives_left", lives_left, tab[i].lives);
      check("playing in round", playing, 1);
      check("game_over in round", game_over, 0);
    end
    start = 1'b0;

    // Fresh round: one hit, then five misses run lives 5 -> 0
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    go_notes[0] = 3'b001;
    go_notes[1] = 3'b010;
    go_notes[2] = 3'b011;
    go_notes[3] = 3'b100;
    go_notes[4] = 3'b000;
    go_notes[5] = 3'b001;
    run_step(go_notes[0], 1, 1'b1, 1'b0, go);
    check("pre-miss score", score, 1);
    check("pre-miss streak", streak, 1);
    for (int k = 1; k <= 5; k++) begin
      run_step(go_notes[k], 1, 1'b0, 1'b1, go);
      check("miss lives", lives_left, 5 - k);
      check("miss streak", streak, 0);
      check("game_over after miss", game_over, (k == 5) ? 1 : 0);
      check("playing after miss", playing, (k == 5) ? 0 : 1);
    end
    repeat (3) @(posedge clk);
    #1;
    check("over holds game_over", game_over, 1);
    check("over holds lives", lives_left, 0);
    check("over holds score", score, 1);
    check("over holds rows", rows, 12'b001_000_100_011);
    check("over check_go", check_go, 0);

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("restart score", score, 0);
    check("restart streak", streak, 0);
    check("restart lives", lives_left, 5);
    check("restart rows", rows, 0);
    check("restart game_over", game_over, 0);
    check("restart playing", playing, 1);

    // Reset while the check is pending
    note_in = 3'b010;
    seen    = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      if (check_go) begin
        seen = 1'b1;
        break;
      end
    end
    check("reached CHECK before reset", seen, 1);
    check("rows before reset", rows, 12'b010_000_000_000);
    #2;
    reset = 1'b1;
    #1;
    check("mid-check reset check_go", check_go, 0);
    check("mid-check reset rows", rows, 0);
    check("mid-check reset lives", lives_left, 0);
    check("mid-check reset playing", playing, 0);
    check("mid-check reset score", score, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("idle after reset playing", playing, 0);
    check("idle after reset check_go", check_go, 0);
    check("idle after reset note_rd", note_rd, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_round_ctrl.md
# note_round_ctrl

Round controller for the four-lane rhythm game. It owns the falling-note playfield (four 3-bit rows) and paces row shifts with a tick counter. After each shift it runs the check_go/check_done handshake with the hit checker, then folds the hit/miss verdict into score, streak and lives. It sits between the note pattern source (upstream) and the hit checker and score display (downstream).

## Interface
- TICK_CYCLES, 25'd12500000: clk cycles spent in WAIT_TICK per note step; must be ≥ 2.
- LIVES, 4'd5: lives loaded at round start, range 1–15.
- SCORE_W, 8: width of score and streak.
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  level; starts a round from IDLE or OVER.
- note_in  in  3  next lane code from the pattern source: 000 empty, 001–100 lanes 3..0, 101–111 treated as empty.
- note_rd  out  1  one-cycle pulse; note_in was consumed this cycle.
- check_done  in  1  hit checker finished.
- hit  in  1  checker verdict, valid while check_done=1.
- miss  in  1  checker verdict, valid while check_done=1.
- check_go  out  1  held high to the checker for the duration of CHECK.
- rows  out  12  playfield: [11:9] row_1 (top) … [2:0] row_4 (bottom).
- row_4  out  3  equals rows[2:0]; drives the checker.
- score  out  SCORE_W  hits this round, saturating.
- streak  out  SCORE_W  consecutive hits, saturating.
- lives_left  out  4  remaining lives.
- playing  out  1  high in WAIT_TICK, SHIFT, CHECK and UPDATE.
- game_over  out  1  high in OVER.

## Operation
- States: IDLE, WAIT_TICK, SHIFT, CHECK, UPDATE, OVER.
- IDLE:
  - start=1 → WAIT_TICK.
  - On that transition: rows cleared, score=0, streak=0, lives_left=LIVES, tick counter loaded with TICK_CYCLES-1.
- WAIT_TICK: the counter decrements each cycle. When it reaches 0 → SHIFT.
- SHIFT (1 cycle):
  - Playfield shifts: row_4←row_3, row_3←row_2, row_2←row_1.
  - row_1←note_in; codes 101–111 load as 000.
  - note_rd=1.
  - → CHECK.
- CHECK:
  - check_go=1 every cycle in this state.
  - Stays until check_done=1. hit and miss are latched in that same cycle.
  - → UPDATE.
- UPDATE (1 cycle):
  - check_go=0.
  - hit=1: score+1 and streak+1, both saturating at 2^SCORE_W-1.
  - Otherwise, if miss=1, or row_4≠000 with hit=0 and miss=0 (unplayed note): streak=0 and lives_left-1.
  - Otherwise (row_4=000, no keys): nothing changes.
  - If hit=1 and miss=1 arrive together, hit wins.
  - Next state: lives_left reaching 0 in this update → OVER; else → WAIT_TICK with the counter reloaded to TICK_CYCLES-1.
- OVER:
  - Score, streak, rows and lives_left hold.
  - start=1 → the same re-initialisation as from IDLE, → WAIT_TICK.
- lives_left never underflows; the decrement only happens when lives_left ≥ 1.

## Timing
- Reset values: state IDLE, rows=0, row_4=0, score=0, streak=0, lives_left=0, check_go=0, note_rd=0, playing=0, game_over=0.
- All outputs are registered; nothing is combinational from the inputs.
- Step period = TICK_CYCLES + 1 (SHIFT) + N (CHECK, N ≥ 1 cycles until check_done) + 1 (UPDATE).
- row_4 is stable throughout CHECK; the checker sees its new value from the first check_go cycle.
- check_go falls in UPDATE, which lets the checker clear check_done before the next CHECK.
- A stale check_done=1 in the first CHECK cycle is accepted; the checker's registered reset guarantees it is low on entry.
- start is ignored in WAIT_TICK through UPDATE.
- Reset mid-round: everything returns to reset values immediately. A pending check is abandoned, with check_go low from the reset edge.
- Score/streak update one cycle after check_done is sampled; game_over rises one cycle after the fatal UPDATE.

## Structure
- The shared game package holds:
  - lane code constants LANE_NONE=000, LANE_3=001, LANE_2=010, LANE_1=011, LANE_0=100;
  - the state enum encoding;
  - the row width constant ROW_W=3.
- One natural sub-module: tick_timer. It is a loadable down-counter with load and en inputs and a zero flag, parameterised by TICK_CYCLES.

## Test plan
- Reset mid-CHECK with check_go=1 → check_go=0, state IDLE, rows=0, lives_left=0 on the reset edge.
- TICK_CYCLES=4, start, note_in=001 five times, checker answers check_done+hit on the 2nd CHECK cycle → after 4 steps row_4=001; the 4th-step UPDATE gives score=1 and streak=1; step period measured as 4+1+2+1 = 8 cycles.
- Unplayed note: row_4=010 in CHECK, check_done with hit=0 and miss=0 → lives_left 5→4, streak→0, score unchanged.
- Miss from LIVES=5 five times → lives_left reaches 0 and game_over=1 the cycle after the 5th UPDATE; start then restarts with score=0 and lives_left=5.
- SCORE_W=2, four consecutive hits → score and streak saturate at 3.
- Empty-row step: row_4=000, checker returns check_done only → no change to score, streak or lives; hit=1 and miss=1 together → counted as a hit.
